// File: rtl/jump_redirect_ctrl_if.sv
// Decode/fetch-facing signal bundle of the jump redirect controller.
// The master side is the pipeline; the slave side is jump_redirect_ctrl.
interface jump_redirect_ctrl_if #(
  parameter int CNT_W = 16
);
  logic              jumpD;
  logic              jump_conflictD;
  logic [31:0]       pc_jumpD;
  logic              stallD_ext;
  logic              flush_except;
  logic              fetch_ready;
  logic              cnt_clr;
  logic              stall_jumpD;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              busy;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output jumpD, jump_conflictD, pc_jumpD, stallD_ext, flush_except,
           fetch_ready, cnt_clr,
    input  stall_jumpD, redirect_valid, redirect_pc, busy, stall_cnt
  );

  modport slave (
    input  jumpD, jump_conflictD, pc_jumpD, stallD_ext, flush_except,
           fetch_ready, cnt_clr,
    output stall_jumpD, redirect_valid, redirect_pc, busy, stall_cnt
  );
endinterface

// File: rtl/jump_redirect_ctrl.sv
// Decode-stage jump sequencer: stalls jr/jalr on operand hazards, latches the
// resolved target and holds a redirect request until fetch accepts it.
module jump_redirect_ctrl #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic                  clk,
  input  logic                  rst,
  jump_redirect_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_OPND = 2'd1,
    REDIRECT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic               redirect_valid_q, redirect_valid_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic               resolve;
  logic               stall_jump;

  assign resolve = bus.jumpD & ~bus.jump_conflictD & ~bus.stallD_ext & ~bus.flush_except;

  // A flush cancels any stall request so the front end can drain.
  assign stall_jump = bus.jumpD & ~bus.flush_except &
                      ((state_q == REDIRECT) | bus.jump_conflictD);

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    if (bus.flush_except) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.jumpD & bus.jump_conflictD) begin
            state_d = WAIT_OPND;
          end else if (resolve) begin
            state_d       = REDIRECT;
            redirect_pc_d = bus.pc_jumpD;
          end
        end
        WAIT_OPND: begin
          if (resolve) begin
            state_d       = REDIRECT;
            redirect_pc_d = bus.pc_jumpD;
          end else if (~bus.jumpD) begin
            state_d = IDLE;
          end
        end
        REDIRECT: begin
          if (bus.fetch_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    redirect_valid_d = (state_d == REDIRECT);
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
    end else if (stall_jump & ~(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      redirect_pc_q    <= RESET_PC;
      redirect_valid_q <= 1'b0;
      stall_cnt_q      <= '0;
    end else begin
      state_q          <= state_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= redirect_valid_d;
      stall_cnt_q      <= stall_cnt_d;
    end
  end

  assign bus.stall_jumpD    = stall_jump;
  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_jump_redirect_ctrl.sv
// Directed bench for jump_redirect_ctrl with hand-computed expectations;
// uses a 4-bit stall counter so saturation is reachable quickly.
module tb_jump_redirect_ctrl;

  localparam int CNT_W = 4;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  jump_redirect_ctrl_if #(.CNT_W(CNT_W)) jif ();

  jump_redirect_ctrl #(.CNT_W(CNT_W), .RESET_PC(32'hbfc00000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (jif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    jif.jumpD          = 1'b0;
    jif.jump_conflictD = 1'b0;
    jif.pc_jumpD       = 32'h0;
    jif.stallD_ext     = 1'b0;
    jif.flush_except   = 1'b0;
    jif.fetch_ready    = 1'b1;
    jif.cnt_clr        = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    idle_inputs();
    tick();
    tick();

    // reset state
    chk("rst_valid", 32'(jif.redirect_valid), 32'h0);
    chk("rst_pc",    jif.redirect_pc,         32'hbfc00000);
    chk("rst_busy",  32'(jif.busy),           32'h0);
    chk("rst_stall", 32'(jif.stall_jumpD),    32'h0);
    chk("rst_cnt",   32'(jif.stall_cnt),      32'h0);
    rst = 1'b0;
    tick();

    // plain j, no conflict
    jif.jumpD    = 1'b1;
    jif.pc_jumpD = 32'h0040_1000;
    #1 chk("j_stall0", 32'(jif.stall_jumpD), 32'h0);
    tick();
    jif.jumpD    = 1'b0;
    jif.pc_jumpD = 32'h0;
    #1;
    chk("j_valid", 32'(jif.redirect_valid), 32'h1);
    chk("j_pc",    jif.redirect_pc,         32'h0040_1000);
    chk("j_busy",  32'(jif.busy),           32'h1);
    chk("j_stall1", 32'(jif.stall_jumpD),   32'h0);
    tick();
    chk("j_valid_off", 32'(jif.redirect_valid), 32'h0);
    chk("j_idle",      32'(jif.busy),           32'h0);
    chk("j_cnt",       32'(jif.stall_cnt),      32'h0);

    // jr with 3-cycle operand conflict
    jif.jumpD          = 1'b1;
    jif.jump_conflictD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("jr_stall", 32'(jif.stall_jumpD), 32'h1);
      tick();
    end
    jif.jump_conflictD = 1'b0;
    jif.pc_jumpD       = 32'h8000_0200;
    #1;
    chk("jr_cnt3",    32'(jif.stall_cnt),      32'h3);
    chk("jr_nostall", 32'(jif.stall_jumpD),    32'h0);
    chk("jr_wait",    32'(jif.redirect_valid), 32'h0);
    tick();
    jif.jumpD    = 1'b0;
    jif.pc_jumpD = 32'h0;
    #1;
    chk("jr_valid", 32'(jif.redirect_valid), 32'h1);
    chk("jr_pc",    jif.redirect_pc,         32'h8000_0200);
    tick();
    chk("jr_done", 32'(jif.redirect_valid), 32'h0);
    jif.cnt_clr = 1'b1;
    tick();
    jif.cnt_clr = 1'b0;
    chk("clr_cnt", 32'(jif.stall_cnt), 32'h0);

    // fetch back-pressure with a second jump arriving during the wait
    jif.fetch_ready = 1'b0;
    jif.jumpD       = 1'b1;
    jif.pc_jumpD    = 32'h0040_2000;
    tick();
    for (int i = 0; i < 4; i++) begin
      jif.jumpD    = (i >= 1);
      jif.pc_jumpD = (i >= 1) ? 32'h1234_5678 : 32'h0;
      #1;
      chk("bp_valid", 32'(jif.redirect_valid), 32'h1);
      chk("bp_pc",    jif.redirect_pc,         32'h0040_2000);
      chk("bp_stall", 32'(jif.stall_jumpD),    (i >= 1) ? 32'h1 : 32'h0);
      tick();
    end
    jif.jumpD       = 1'b0;
    jif.pc_jumpD    = 32'h0;
    jif.fetch_ready = 1'b1;
    #1 chk("bp_still", 32'(jif.redirect_valid), 32'h1);
    tick();
    chk("bp_idle",  32'(jif.busy),           32'h0);
    chk("bp_off",   32'(jif.redirect_valid), 32'h0);
    chk("bp_cnt",   32'(jif.stall_cnt),      32'h3);
    jif.cnt_clr = 1'b1;
    tick();
    jif.cnt_clr = 1'b0;

    // flush in the same cycle as a resolving jump
    jif.jumpD        = 1'b1;
    jif.pc_jumpD     = 32'hdead_beef;
    jif.flush_except = 1'b1;
    #1 chk("fl_stall", 32'(jif.stall_jumpD), 32'h0);
    tick();
    jif.jumpD        = 1'b0;
    jif.flush_except = 1'b0;
    #1;
    chk("fl_valid", 32'(jif.redirect_valid), 32'h0);
    chk("fl_busy",  32'(jif.busy),           32'h0);
    chk("fl_pc",    jif.redirect_pc,         32'h0040_2000);

    // flush while in REDIRECT
    jif.fetch_ready = 1'b0;
    jif.jumpD       = 1'b1;
    jif.pc_jumpD    = 32'h0040_3000;
    tick();
    jif.jumpD = 1'b0;
    #1 chk("flr_valid", 32'(jif.redirect_valid), 32'h1);
    jif.flush_except = 1'b1;
    tick();
    jif.flush_except = 1'b0;
    chk("flr_drop", 32'(jif.redirect_valid), 32'h0);
    chk("flr_busy", 32'(jif.busy),           32'h0);

    // stallD_ext blocks resolution until it drops
    jif.fetch_ready = 1'b1;
    jif.stallD_ext  = 1'b1;
    jif.jumpD       = 1'b1;
    jif.pc_jumpD    = 32'h0040_4000;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("sx_hold", 32'(jif.busy), 32'h0);
    end
    jif.stallD_ext = 1'b0;
    tick();
    jif.jumpD = 1'b0;
    #1;
    chk("sx_valid", 32'(jif.redirect_valid), 32'h1);
    chk("sx_pc",    jif.redirect_pc,         32'h0040_4000);
    tick();

    // counter saturation and clear priority
    jif.jumpD          = 1'b1;
    jif.jump_conflictD = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("sat_cnt",  32'(jif.stall_cnt), 32'hf);
    chk("sat_busy", 32'(jif.busy),      32'h1);
    jif.cnt_clr = 1'b1;
    tick();
    jif.cnt_clr = 1'b0;
    chk("clr_pri", 32'(jif.stall_cnt), 32'h0);
    tick();
    chk("clr_inc", 32'(jif.stall_cnt), 32'h1);
    jif.jumpD          = 1'b0;
    jif.jump_conflictD = 1'b0;
    tick();
    chk("wo_exit", 32'(jif.busy), 32'h0);

    // async reset during REDIRECT
    jif.fetch_ready = 1'b0;
    jif.jumpD       = 1'b1;
    jif.pc_jumpD    = 32'h0040_5000;
    tick();
    jif.jumpD = 1'b0;
    #1 chk("ar_valid", 32'(jif.redirect_valid), 32'h1);
    rst = 1'b1;
    #1;
    chk("ar_drop", 32'(jif.redirect_valid), 32'h0);
    chk("ar_pc",   jif.redirect_pc,         32'hbfc00000);
    chk("ar_busy", 32'(jif.busy),           32'h0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("ar_quiet", 32'(jif.redirect_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
